// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and op-class helper for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_SLL   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLTU  = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_MUL   = 4'b1010;
   localparam logic [3:0] ALU_MULHU = 4'b1011;
   localparam logic [3:0] ALU_DIVU  = 4'b1100;
   localparam logic [3:0] ALU_REMU  = 4'b1101;
   localparam logic [3:0] ALU_DIV   = 4'b1110;
   localparam logic [3:0] ALU_REM   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } alu_state_e;

   function automatic logic is_muldiv(input logic [3:0] op);
      return op[3] && (op[2] || op[1]);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with sign fixup; one step per cycle.
// Only built when ALU_MC_MULDIV_EN is defined.
`ifdef ALU_MC_MULDIV_EN
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            last_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CNT_W = $clog2(XLEN);

   logic             active_q, active_d, done_q, done_d, qneg_q, qneg_d, rneg_q, rneg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [XLEN-1:0]  a_mag, b_mag, rem_nx;
   logic [XLEN:0]    mul_sum, rem_sh;
   logic             sgn, ge;

   assign sgn     = (op_i == ALU_DIV) || (op_i == ALU_REM);
   assign a_mag   = (sgn && a_i[XLEN-1]) ? -a_i : a_i;
   assign b_mag   = (sgn && b_i[XLEN-1]) ? -b_i : b_i;
   // hi holds the partial product (mul) or the partial remainder (div); lo the multiplier / quotient
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign rem_sh  = {hi_q, lo_q[XLEN-1]};
   assign ge      = rem_sh >= {1'b0, opnd_q};
   assign rem_nx  = ge ? XLEN'(rem_sh - {1'b0, opnd_q}) : rem_sh[XLEN-1:0];
   assign last_o  = active_q && (cnt_q == '0);
   assign done_o  = done_q;

   always_comb begin
      active_d = active_q;
      done_d   = last_o;
      cnt_d    = cnt_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      if (start_i) begin
         active_d = 1'b1;
         done_d   = 1'b0;
         cnt_d    = CNT_W'(XLEN - 1);
         op_d     = op_i;
         hi_d     = '0;
         if (op_i[2]) begin
            lo_d   = a_mag;
            opnd_d = b_mag;
         end else begin
            lo_d   = b_i;
            opnd_d = a_i;
         end
         qneg_d = sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]);
         rneg_d = sgn && a_i[XLEN-1];
      end else if (active_q) begin
         if (op_q[2]) begin
            hi_d = rem_nx;
            lo_d = {lo_q[XLEN-2:0], ge};
         end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
         end
         if (cnt_q == '0) active_d = 1'b0;
         else             cnt_d    = cnt_q - 1'b1;
      end
   end

   always_comb begin
      case (op_q)
         ALU_MULHU, ALU_REMU: result_o = hi_q;
         ALU_DIV:             result_o = qneg_q ? -lo_q : lo_q;
         ALU_REM:             result_o = rneg_q ? -hi_q : hi_q;
         default:             result_o = lo_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
      end
   end
endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and registered result/zero.
// ALU_MC_MULDIV_EN builds the iterative mul/div path; otherwise ops 1010-1111 return 0.
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | iterative mul/div stepping
// FIXUP | sign correction and result select
// DONE  | result valid, held until out_ready
module alu_mc
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);
   alu_state_e         state_q, state_d;
   logic [XLEN-1:0]    result_q, result_d, alu_y;
   logic               zero_q, zero_d, accept, slow_op;
   logic [SHAMT_W-1:0] shamt;

   assign shamt     = b[SHAMT_W-1:0];
   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

`ifdef ALU_MC_MULDIV_EN
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic            div_op, div_by_zero, div_ovf, md_last, md_done;
   logic [XLEN-1:0] md_result;

   assign div_op      = alu_control[3] && alu_control[2];
   assign div_by_zero = div_op && (b == '0);
   assign div_ovf     = div_op && alu_control[1] && (a == MOST_NEG) && (b == '1);
   // divide special cases take the single-cycle path
   assign slow_op     = is_muldiv(alu_control) && !div_by_zero && !div_ovf;
   assign busy        = (state_q == ST_BUSY) || (state_q == ST_FIXUP);

   alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start_i  (accept && slow_op),
      .op_i     (alu_control),
      .a_i      (a),
      .b_i      (b),
      .last_o   (md_last),
      .done_o   (md_done),
      .result_o (md_result)
   );
`else
   assign slow_op = 1'b0;
   assign busy    = 1'b0;
`endif

   always_comb begin
      alu_y = '0;
      case (alu_control)
         ALU_AND:  alu_y = a & b;
         ALU_OR:   alu_y = a | b;
         ALU_ADD:  alu_y = a + b;
         ALU_XOR:  alu_y = a ^ b;
         ALU_SLL:  alu_y = a << shamt;
         ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SUB:  alu_y = a - b;
         ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_SRL:  alu_y = a >> shamt;
         ALU_SRA:  alu_y = $signed(a) >>> shamt;
`ifdef ALU_MC_MULDIV_EN
         ALU_DIVU: alu_y = '1;
         ALU_REMU: alu_y = a;
         ALU_DIV:  alu_y = (b == '0) ? '1 : a;
         ALU_REM:  alu_y = (b == '0) ? a : '0;
`endif
         default:  alu_y = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      if (accept) begin
         if (slow_op) begin
            state_d = ST_BUSY;
         end else begin
            state_d  = ST_DONE;
            result_d = alu_y;
            zero_d   = (alu_y == '0);
         end
      end else begin
         case (state_q)
`ifdef ALU_MC_MULDIV_EN
            ST_BUSY:  if (md_last) state_d = ST_FIXUP;
            ST_FIXUP: if (md_done) begin
               state_d  = ST_DONE;
               result_d = md_result;
               zero_d   = (md_result == '0);
            end
`endif
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at accept, compared when out_valid appears.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic [3:0]  alu_control;
   logic [31:0] a, b, result;
   logic        in_ready, out_valid, zero, busy;

   logic [31:0] sb_q[$];
   int          vec_cnt = 0;
   int          err_cnt = 0;

   alu_mc dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      p = {32'd0, x} * {32'd0, y};
      case (op)
         ALU_AND:   return x & y;
         ALU_OR:    return x | y;
         ALU_ADD:   return x + y;
         ALU_XOR:   return x ^ y;
         ALU_SLL:   return x << y[4:0];
         ALU_SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_SUB:   return x - y;
         ALU_SLTU:  return (x < y) ? 32'd1 : 32'd0;
         ALU_SRL:   return x >> y[4:0];
         ALU_SRA:   return $signed(x) >>> y[4:0];
`ifdef ALU_MC_MULDIV_EN
         ALU_MUL:   return p[31:0];
         ALU_MULHU: return p[63:32];
         ALU_DIVU:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
         ALU_REMU:  return (y == 0) ? x : x % y;
         ALU_DIV:   return (y == 0) ? 32'hFFFF_FFFF :
                           (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : $signed(x) / $signed(y);
         ALU_REM:   return (y == 0) ? x :
                           (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'd0 : $signed(x) % $signed(y);
`endif
         default:   return 32'd0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp_r);
      int guard = 0;
      alu_control = op; a = x; b = y; in_valid = 1'b1;
      while (!in_ready && guard < 200) begin tick(); guard++; end
      tick();
      in_valid = 1'b0; a = $urandom; b = $urandom;
      sb_q.push_back(exp_r);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin tick(); lat++; end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_control = '0; a = '0; b = '0;
      repeat (3) tick();
      reset = 1'b0;
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      vec_cnt++; if (result !== 32'd0) begin err_cnt++; $display("FAIL reset_result got=%h want=0", result); end
      vec_cnt++; if (zero !== 1'b0) begin err_cnt++; $display("FAIL reset_zero got=%b want=0", zero); end
      vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b want=0", busy); end
   endtask

   task automatic test_single();
      logic [3:0]  ops [10];
      logic [31:0] xs [10], ys [10], es [10];
      logic [31:0] exp_r;
      int lat;
      ops = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL};
      xs  = '{32'd5, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_1234,
              32'h0F00_0001, 32'hAAAA_5555, 32'h0000_0003, 32'h8000_0000};
      ys  = '{32'd7, 32'd9, 32'd1, 32'd1, 32'h21, 32'h0FF0_FF00,
              32'h1000_0010, 32'hFFFF_0000, 32'h0000_0024, 32'h0000_001F};
      es  = '{32'd12, 32'd0, 32'd1, 32'd0, 32'hC000_0000, 32'h00F0_1200,
              32'h1F00_0011, 32'h5555_5555, 32'h0000_0030, 32'h0000_0001};
      for (int i = 0; i < 10; i++) begin
         send(ops[i], xs[i], ys[i], es[i]);
         wait_out(lat);
         exp_r = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
         vec_cnt++; if (lat != 1) begin err_cnt++; $display("FAIL single_latency op=%h got=%0d want=1", ops[i], lat); end
         vec_cnt++; if (result !== exp_r) begin err_cnt++; $display("FAIL single_result op=%h got=%h want=%h", ops[i], result, exp_r); end
         vec_cnt++; if (zero !== (exp_r == 0)) begin err_cnt++; $display("FAIL single_zero op=%h got=%b want=%b", ops[i], zero, exp_r == 0); end
      end
   endtask

   task automatic test_muldiv();
      logic [3:0]  ops [12];
      logic [31:0] xs [12], ys [12], es [12];
      int          ls [12];
      logic [31:0] exp_r;
      int lat, busy_bad;
      ops = '{ALU_MUL, ALU_MULHU, ALU_DIV, ALU_REM, ALU_DIVU, ALU_DIV,
              ALU_REMU, ALU_REM, ALU_DIVU, ALU_REMU, ALU_MUL, ALU_MULHU};
      xs  = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
              32'd7, 32'h8000_0000, 32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      ys  = '{32'h0001_0000, 32'h0001_0000, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF,
              32'd0, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`ifdef ALU_MC_MULDIV_EN
      es  = '{32'd0, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
              32'd7, 32'd0, 32'd14, 32'd2, 32'd1, 32'hFFFF_FFFE};
      ls  = '{34, 34, 34, 34, 1, 1, 1, 1, 34, 34, 34, 34};
`else
      es  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      ls  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
      for (int i = 0; i < 12; i++) begin
         send(ops[i], xs[i], ys[i], es[i]);
         lat = 1; busy_bad = 0;
         while (!out_valid && lat < 200) begin
            if (busy !== 1'b1) busy_bad++;
            tick(); lat++;
         end
         exp_r = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
         vec_cnt++; if (lat != ls[i]) begin err_cnt++; $display("FAIL md_latency i=%0d got=%0d want=%0d", i, lat, ls[i]); end
         vec_cnt++; if (busy_bad != 0) begin err_cnt++; $display("FAIL md_busy_low i=%0d got=%0d want=0", i, busy_bad); end
         vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL md_busy_done i=%0d got=%b want=0", i, busy); end
         vec_cnt++; if (result !== exp_r) begin err_cnt++; $display("FAIL md_result i=%0d got=%h want=%h", i, result, exp_r); end
         vec_cnt++; if (zero !== (exp_r == 0)) begin err_cnt++; $display("FAIL md_zero i=%0d got=%b want=%b", i, zero, exp_r == 0); end
      end
   endtask

   task automatic test_hold();
      logic [31:0] exp_r;
      int lat;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      send(ALU_ADD, 32'd3, 32'd4, 32'd7);
      wait_out(lat);
      vec_cnt++; if (lat != 1) begin err_cnt++; $display("FAIL hold_latency got=%0d want=1", lat); end
      alu_control = ALU_ADD; a = 32'd10; b = 32'd20; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         vec_cnt++; if (result !== 32'd7 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_stable cyc=%0d got=%h/%b want=7/1", i, result, out_valid); end
         vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      end
      out_ready = 1'b1;
      #1;
      vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL hold_release_ready got=%b want=1", in_ready); end
      exp_r = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      vec_cnt++; if (result !== exp_r) begin err_cnt++; $display("FAIL hold_first_result got=%h want=%h", result, exp_r); end
      tick();
      in_valid = 1'b0;
      sb_q.push_back(32'd30);
      exp_r = sb_q.pop_front();
      vec_cnt++; if (out_valid !== 1'b1 || result !== exp_r) begin err_cnt++; $display("FAIL b2b_next got=%b/%h want=1/%h", out_valid, result, exp_r); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_r;
      int lat;
      out_ready = 1'b1;
      send(ALU_DIVU, 32'd1000, 32'd3, model(ALU_DIVU, 32'd1000, 32'd3));
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb_q.delete();
      vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rmid_idle got=%b want=1", in_ready); end
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got=%b want=0", busy); end
      vec_cnt++; if (result !== 32'd0 || zero !== 1'b0) begin err_cnt++; $display("FAIL rmid_result got=%h/%b want=0/0", result, zero); end
      tick();
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_discard got=%b want=0", out_valid); end
      send(ALU_ADD, 32'd1, 32'd1, 32'd2);
      wait_out(lat);
      exp_r = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      vec_cnt++; if (lat != 1 || result !== exp_r) begin err_cnt++; $display("FAIL rmid_add got=%0d/%h want=1/%h", lat, result, exp_r); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  op;
      logic [31:0] x, y, exp_r;
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op = 4'($urandom_range(0, 15));
         x  = $urandom;
         y  = (i % 4 == 3) ? 32'd0 : $urandom;
         send(op, x, y, model(op, x, y));
         wait_out(lat);
         exp_r = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
         vec_cnt++; if (out_valid !== 1'b1 || result !== exp_r) begin err_cnt++; $display("FAIL rand_result op=%h a=%h b=%h got=%h want=%h", op, x, y, result, exp_r); end
         vec_cnt++; if (zero !== (exp_r == 0)) begin err_cnt++; $display("FAIL rand_zero op=%h got=%b want=%b", op, zero, exp_r == 0); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_muldiv();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
